// File: rtl/cpu_reg_scoreboard.sv
// Issue-stage scoreboard for pending multiply write-backs: stalls decode on RAW/WAW hazards and a full mul pipe.
// Latency: stall is combinational from registered state; busy/count/error updates are visible one cycle later.
// Backpressure: issue_stall holds decode; write-back ports are never stalled, only monitored.
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

module cpu_reg_scoreboard #(
    parameter int NUM_REGS       = `NUM_REGS,
    parameter int MUL_DEPTH      = 4,
    parameter bit ZERO_HARDWIRED = 1'b1,
    localparam int RW            = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [RW-1:0]       issue_ra,
    input  logic [RW-1:0]       issue_rb,
    input  logic                issue_ra_used,
    input  logic                issue_rb_used,
    input  logic [RW-1:0]       issue_rd,
    input  logic                issue_rd_used,
    input  logic                issue_is_mul,
    output logic                issue_stall,
    input  logic                wb_enable,
    input  logic [RW-1:0]       wb_reg,
    input  logic                mul_wb_enable,
    input  logic [RW-1:0]       mul_wb_reg,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [3:0]          mul_inflight,
    output logic [1:0]          sb_error
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          err_q, err_d;

    logic fire, set_en, inc, dec, wb_zero, mul_zero, depth_full;

    assign depth_full = (cnt_q == 4'(MUL_DEPTH));

    // Stall looks only at registered state: a write-back this cycle does not bypass.
    always_comb begin
        issue_stall = 1'b0;
        if (issue_valid) begin
            issue_stall = (issue_ra_used & busy_q[issue_ra])
                        | (issue_rb_used & busy_q[issue_rb])
                        | (issue_rd_used & busy_q[issue_rd])
                        | (issue_is_mul  & depth_full);
        end
    end

    assign fire     = issue_valid & ~issue_stall;
    assign inc      = fire & issue_is_mul;
    assign set_en   = inc & issue_rd_used & ~(ZERO_HARDWIRED && (issue_rd == '0));
    assign dec      = mul_wb_enable & (cnt_q != 4'd0);
    assign wb_zero  = ZERO_HARDWIRED && (wb_reg == '0);
    assign mul_zero = ZERO_HARDWIRED && (mul_wb_reg == '0);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (mul_wb_enable) begin
            busy_d[mul_wb_reg] = 1'b0;
            if ((~busy_q[mul_wb_reg] & ~mul_zero) | (cnt_q == 4'd0)) begin
                err_d[0] = 1'b1;
            end
        end
        // WAW stalls guarantee the set never targets the register being cleared.
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (inc & ~dec) begin
            cnt_d = cnt_q + 4'd1;
        end else if (dec & ~inc) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (wb_enable & mul_wb_enable & (wb_reg == mul_wb_reg) & ~wb_zero) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_mask    = busy_q;
    assign mul_inflight = cnt_q;
    assign sb_error     = err_q;

endmodule
